// File: rtl/crc_pkg.sv
// Shared types for the parallel CRC engine: operating mode, FSM states, error-counter width.
package crc_pkg;

  typedef enum logic {CRC_ENCODE, CRC_CHECK} crc_mode_e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} crc_state_e;

  localparam int CRC_ERRCNT_W = 16;

endpackage

// File: rtl/crc_step.sv
// Combinational CRC update over BITSPERCYCLE message bits, MSB first; zero latency, no flow control.
module crc_step #(
  parameter int CRCWIDTH     = 16,
  parameter int BITSPERCYCLE = 1
) (
  input  logic [CRCWIDTH-1:0]     crc_i,
  input  logic [CRCWIDTH-1:0]     poly_i,
  input  logic [BITSPERCYCLE-1:0] bits_i,
  output logic [CRCWIDTH-1:0]     crc_o
);

  logic [CRCWIDTH-1:0] crc_v;
  logic                fb_v;

  // bits_i[BITSPERCYCLE-1] is the earliest message bit of this chunk
  always_comb begin
    crc_v = crc_i;
    fb_v  = 1'b0;
    for (int i = BITSPERCYCLE - 1; i >= 0; i--) begin
      fb_v  = crc_v[CRCWIDTH-1] ^ bits_i[i];
      crc_v = {crc_v[CRCWIDTH-2:0], 1'b0} ^ (fb_v ? poly_i : '0);
    end
    crc_o = crc_v;
  end

endmodule

// File: rtl/crc_engine_par.sv
// Parallel CRC encode/check of one DATAWIDTH word; crcvalid DATAWIDTH/BITSPERCYCLE+1 cycles after the start.
// Starts are taken only while crcready=1 and never queued; CRC_ERRCNT_EN adds a saturating errcnt output.
module crc_engine_par
  import crc_pkg::*;
#(
  parameter int DATAWIDTH    = 32,
  parameter int CRCWIDTH     = 16,
  parameter int BITSPERCYCLE = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ctrlen,
  input  logic                    mode,
  input  logic [DATAWIDTH-1:0]    datain,
  input  logic [CRCWIDTH:0]       genPoly,
  output logic [CRCWIDTH-1:0]     crcSeq,
  output logic                    crcready,
  output logic                    crcvalid,
`ifdef CRC_ERRCNT_EN
  output logic [CRC_ERRCNT_W-1:0] errcnt,
`endif
  output logic                    crcerror
);

  localparam int NSTEP = DATAWIDTH / BITSPERCYCLE;
  localparam int CNTW  = $clog2(NSTEP) + 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NSTEP - 1);

  crc_state_e              state_q;
  crc_mode_e               mode_q;
  logic [DATAWIDTH-1:0]    data_q, data_d;
  logic [CRCWIDTH-1:0]     poly_q;
  logic [CRCWIDTH-1:0]     crc_q, crc_d;
  logic [CNTW-1:0]         cnt_q;
  logic [CRCWIDTH-1:0]     seq_q;
  logic                    vld_q, err_q, rdy_q;

  // The x^CRCWIDTH term is implicit in the shift-register structure.
  logic unused_poly_msb;
  assign unused_poly_msb = genPoly[CRCWIDTH];

  crc_step #(
    .CRCWIDTH    (CRCWIDTH),
    .BITSPERCYCLE(BITSPERCYCLE)
  ) u_step (
    .crc_i (crc_q),
    .poly_i(poly_q),
    .bits_i(data_q[DATAWIDTH-1 -: BITSPERCYCLE]),
    .crc_o (crc_d)
  );

  assign data_d = data_q << BITSPERCYCLE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      mode_q  <= CRC_ENCODE;
      data_q  <= '0;
      poly_q  <= '0;
      crc_q   <= '0;
      cnt_q   <= '0;
      seq_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ctrlen) begin
            data_q  <= datain;
            poly_q  <= genPoly[CRCWIDTH-1:0];
            mode_q  <= crc_mode_e'(mode);
            crc_q   <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          crc_q  <= crc_d;
          data_q <= data_d;
          cnt_q  <= cnt_q + 1'b1;
          // Result and error are latched here so they are stable before crcvalid rises.
          if (cnt_q == LAST) begin
            seq_q   <= crc_d;
            err_q   <= (mode_q == CRC_CHECK) && (crc_d != '0);
            state_q <= DONE;
          end
        end
        DONE: begin
          vld_q   <= 1'b1;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign crcSeq   = seq_q;
  assign crcready = rdy_q;
  assign crcvalid = vld_q;
  assign crcerror = err_q;

`ifdef CRC_ERRCNT_EN
  logic [CRC_ERRCNT_W-1:0] errcnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      errcnt_q <= '0;
    end else if (state_q == DONE && err_q && errcnt_q != '1) begin
      errcnt_q <= errcnt_q + 1'b1;
    end
  end

  assign errcnt = errcnt_q;
`endif

endmodule
